life_col_scan: RTL

Reader and sequencer for a grid of Life columns. Steps the array one generation on request. On a scan request it snapshots every cell's current and previous state, then streams them out one cell per beat over a valid/ready interface. It sits between the column array and display or host logic. It drives the array's column enable and consumes the per-column alive and previous-alive status vectors.

---
 rtl/life_pkg.sv | 31 +++
 rtl/life_scan_idx.sv | 47 ++++
 rtl/life_col_scan.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/life_pkg.sv
// Shared types and width helpers for the Life column scanner.
package life_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STEP,
    CAPTURE,
    SCAN
  } scan_state_t;

  // Column index width; a single column still needs one bit of index.
  function automatic int col_w(input int cols);
    return (cols > 1) ? $clog2(cols) : 1;
  endfunction

  // Row index width.
  function automatic int row_w(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

  // Width of a flat cell index into a COLS*ROWS vector.
  function automatic int idx_w(input int cols, input int rows);
    return (cols * rows > 1) ? $clog2(cols * rows) : 1;
  endfunction

  // Width needed to count every cell, including the all-alive case.
  function automatic int cnt_w(input int cols, input int rows);
    return $clog2(cols * rows + 1);
  endfunction

endpackage

// File: rtl/life_scan_idx.sv
// Column-major cell counter: row advances first, wraps, then column advances.
module life_scan_idx
  import life_pkg::*;
#(
  parameter int COLS = 4,
  parameter int ROWS = 4,
  localparam int CW = col_w(COLS),
  localparam int RW = row_w(ROWS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          advance,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          last
);

  logic row_wrap;
  logic col_wrap;

  // Wrap points of each counter.
  always_comb begin
    row_wrap = (row == RW'(ROWS - 1));
    col_wrap = (col == CW'(COLS - 1));
    last     = row_wrap && col_wrap;
  end

  // Counter update; clear has priority so a fresh scan always starts at cell 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col <= '0;
      row <= '0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
    end else if (advance) begin
      if (row_wrap) begin
        row <= '0;
        col <= col_wrap ? '0 : col + CW'(1);
      end else begin
        row <= row + RW'(1);
      end
    end
  end

endmodule

// File: rtl/life_col_scan.sv
// Life array sequencer: single-cycle generation steps and snapshot scans
// streamed out one cell per valid/ready beat. Reset is asynchronous, active-low.
// Optional live-cell counter on pop_count when LIFE_SCAN_POP_EN is defined.
module life_col_scan
  import life_pkg::*;
#(
  parameter int COLS = 4,
  parameter int ROWS = 4,
  localparam int N  = COLS * ROWS,
  localparam int CW = col_w(COLS),
  localparam int RW = row_w(ROWS),
  localparam int IW = idx_w(COLS, ROWS),
  localparam int NW = cnt_w(COLS, ROWS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  alive_cols,
  input  logic [N-1:0]  alive_prev_cols,
  input  logic          step_req,
  input  logic          scan_req,
  output logic          array_enable,
  output logic          busy,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_alive,
  output logic          out_changed,
  output logic [CW-1:0] out_col,
  output logic [RW-1:0] out_row,
  output logic          out_last,
  output logic          done
`ifdef LIFE_SCAN_POP_EN
  ,
  output logic [NW-1:0] pop_count
`endif
);

  scan_state_t state;
  scan_state_t state_next;

  logic [N-1:0]  shadow_alive;
  logic [N-1:0]  shadow_prev;
  logic [CW-1:0] idx_col;
  logic [RW-1:0] idx_row;
  logic          idx_last;
  logic [IW-1:0] cell_idx;
  logic          in_scan;
  logic          beat_accept;
  logic          last_accept;
  logic          cell_alive;

  life_scan_idx #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_idx (
    .clk     (clk),
    .reset   (reset),
    .clear   (state == CAPTURE),
    .advance (beat_accept),
    .col     (idx_col),
    .row     (idx_row),
    .last    (idx_last)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; requests outside IDLE are dropped and scan beats step.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (scan_req) begin
          state_next = CAPTURE;
        end else if (step_req) begin
          state_next = STEP;
        end
      end
      STEP:    state_next = IDLE;
      CAPTURE: state_next = SCAN;
      SCAN: begin
        if (last_accept) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake decode and the snapshot cell selected by the counters.
  always_comb begin
    in_scan     = (state == SCAN);
    beat_accept = in_scan && out_ready;
    last_accept = beat_accept && idx_last;
    cell_idx    = IW'(idx_col) * IW'(ROWS) + IW'(idx_row);
    cell_alive  = shadow_alive[cell_idx];
  end

  // Output stream is driven only during SCAN so everything reads 0 otherwise.
  always_comb begin
    array_enable = (state == STEP);
    busy         = (state != IDLE);
    out_valid    = in_scan;
    out_alive    = in_scan && cell_alive;
    out_changed  = in_scan && (cell_alive ^ shadow_prev[cell_idx]);
    out_col      = in_scan ? idx_col : '0;
    out_row      = in_scan ? idx_row : '0;
    out_last     = in_scan && idx_last;
  end

  // Snapshot both generations in CAPTURE so later array changes cannot leak in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_alive <= '0;
      shadow_prev  <= '0;
    end else if (state == CAPTURE) begin
      shadow_alive <= alive_cols;
      shadow_prev  <= alive_prev_cols;
    end
  end

  // Completion pulse in the cycle after the final beat is taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done <= 1'b0;
    end else begin
      done <= last_accept;
    end
  end

`ifdef LIFE_SCAN_POP_EN
  // Live-cell tally over accepted beats; holds after the scan until the next capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pop_count <= '0;
    end else if (state == CAPTURE) begin
      pop_count <= '0;
    end else if (beat_accept && cell_alive) begin
      pop_count <= pop_count + NW'(1);
    end
  end
`endif

endmodule
